// File: rtl/kbd_ps2_matrix.sv
// kbd_ps2_matrix: PS/2 set-2 receiver that maintains the 64-bit Z88 key-down matrix (bit = col*8+row).
// Optional frame watchdog is built when KBD_PS2_TMO_EN is defined.
module kbd_ps2_matrix #(
  parameter int unsigned FILT_LEN = 8,
  parameter int unsigned TMO_BITS = 15
) (
  input  logic        mck,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_dat,
  output logic [63:0] kbmat,
  output logic        scan_vld,
  output logic [7:0]  scan_code,
  output logic        frm_err
);

  localparam int unsigned FCW = $clog2(FILT_LEN + 1);

  typedef enum logic [1:0] {IDLE, DATA, PAR, STOP} state_e;

  // index 0 carries the PS/2 clock, index 1 the PS/2 data
  logic [1:0]     s1_q, s2_q;
  logic [1:0]     filt_q, filt_d;
  logic [FCW-1:0] fcnt_q [2];
  logic [FCW-1:0] fcnt_d [2];
  logic           fall_q, fall_d;
  logic           dat_c;

  state_e         state_q, state_d;
  logic [2:0]     bcnt_q, bcnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           par_q, par_d;
  logic           vld_q, vld_d;
  logic           err_q, err_d;
  logic [7:0]     code_q, code_d;
  logic           tmo_hit_c;

  logic [63:0]    kbmat_q, kbmat_d;
  logic           ext_q, ext_d;
  logic           brk_q, brk_d;
  logic [6:0]     lk_c;

  // Fixed set-2 map: {ext, code} -> {hit, bit index}
  function automatic logic [6:0] rom_lookup(input logic ext, input logic [7:0] code);
    logic [6:0] r;
    r = '0;
    case ({ext, code})
      9'h03E: r = {1'b1, 6'd0};
      9'h03D: r = {1'b1, 6'd1};
      9'h031: r = {1'b1, 6'd2};
      9'h175: r = {1'b1, 6'd3};
      9'h035: r = {1'b1, 6'd4};
      9'h033: r = {1'b1, 6'd5};
      9'h05A: r = {1'b1, 6'd6};
      9'h066: r = {1'b1, 6'd7};
      9'h036: r = {1'b1, 6'd8};
      9'h02E: r = {1'b1, 6'd9};
      9'h032: r = {1'b1, 6'd10};
      9'h172: r = {1'b1, 6'd11};
      9'h02C: r = {1'b1, 6'd12};
      9'h034: r = {1'b1, 6'd13};
      9'h03C: r = {1'b1, 6'd14};
      9'h03B: r = {1'b1, 6'd15};
      9'h025: r = {1'b1, 6'd16};
      9'h026: r = {1'b1, 6'd17};
      9'h02A: r = {1'b1, 6'd18};
      9'h174: r = {1'b1, 6'd19};
      9'h02D: r = {1'b1, 6'd20};
      9'h02B: r = {1'b1, 6'd21};
      9'h043: r = {1'b1, 6'd22};
      9'h042: r = {1'b1, 6'd23};
      9'h01E: r = {1'b1, 6'd24};
      9'h016: r = {1'b1, 6'd25};
      9'h021: r = {1'b1, 6'd26};
      9'h03A: r = {1'b1, 6'd27};
      9'h024: r = {1'b1, 6'd28};
      9'h023: r = {1'b1, 6'd29};
      9'h044: r = {1'b1, 6'd30};
      9'h04B: r = {1'b1, 6'd31};
      9'h045: r = {1'b1, 6'd32};
      9'h046: r = {1'b1, 6'd33};
      9'h022: r = {1'b1, 6'd34};
      9'h041: r = {1'b1, 6'd35};
      9'h01D: r = {1'b1, 6'd36};
      9'h01B: r = {1'b1, 6'd37};
      9'h04D: r = {1'b1, 6'd38};
      9'h04C: r = {1'b1, 6'd39};
      9'h04E: r = {1'b1, 6'd40};
      9'h055: r = {1'b1, 6'd41};
      9'h01A: r = {1'b1, 6'd42};
      9'h049: r = {1'b1, 6'd43};
      9'h01C: r = {1'b1, 6'd44};
      9'h015: r = {1'b1, 6'd45};
      9'h054: r = {1'b1, 6'd46};
      9'h052: r = {1'b1, 6'd47};
      9'h05D: r = {1'b1, 6'd48};
      9'h05B: r = {1'b1, 6'd49};
      9'h04A: r = {1'b1, 6'd50};
      9'h00D: r = {1'b1, 6'd51};
      9'h076: r = {1'b1, 6'd52};
      9'h029: r = {1'b1, 6'd53};
      9'h012: r = {1'b1, 6'd54};
      9'h058: r = {1'b1, 6'd55};
      9'h00E: r = {1'b1, 6'd56};
      9'h059: r = {1'b1, 6'd57};
      9'h014: r = {1'b1, 6'd58};
      9'h16B: r = {1'b1, 6'd59};
      9'h011: r = {1'b1, 6'd60};
      9'h005: r = {1'b1, 6'd61};
      9'h006: r = {1'b1, 6'd62};
      9'h004: r = {1'b1, 6'd63};
      default: r = '0;
    endcase
    return r;
  endfunction

  // Glitch filter: a level is taken only after FILT_LEN consecutive differing samples
  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < 2; i++) begin
      fcnt_d[i] = '0;
      if (s2_q[i] != filt_q[i]) begin
        if (fcnt_q[i] == FCW'(FILT_LEN - 1)) filt_d[i] = s2_q[i];
        else fcnt_d[i] = fcnt_q[i] + FCW'(1);
      end
    end
    fall_d = filt_q[0] & ~filt_d[0];
  end

  always_ff @(posedge mck) begin
    if (rst) begin
      s1_q      <= 2'b11;
      s2_q      <= 2'b11;
      filt_q    <= 2'b11;
      fcnt_q[0] <= '0;
      fcnt_q[1] <= '0;
      fall_q    <= 1'b0;
    end else begin
      s1_q      <= {ps2_dat, ps2_clk};
      s2_q      <= s1_q;
      filt_q    <= filt_d;
      fcnt_q[0] <= fcnt_d[0];
      fcnt_q[1] <= fcnt_d[1];
      fall_q    <= fall_d;
    end
  end

  assign dat_c = filt_q[1];

`ifdef KBD_PS2_TMO_EN
  logic [TMO_BITS-1:0] tmo_q, tmo_d;

  // Watchdog restarts on every clock fall and only runs inside a frame
  always_comb begin
    tmo_d = '0;
    if ((state_q != IDLE) && !fall_q) tmo_d = tmo_q + TMO_BITS'(1);
  end

  assign tmo_hit_c = (state_q != IDLE) && !fall_q && (tmo_q == '1);

  always_ff @(posedge mck) begin
    if (rst) tmo_q <= '0;
    else     tmo_q <= tmo_d;
  end
`else
  logic tmo_unused_c;
  assign tmo_unused_c = TMO_BITS[0];
  assign tmo_hit_c    = 1'b0;
`endif

  // Frame receiver
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    par_d   = par_q;
    vld_d   = 1'b0;
    err_d   = 1'b0;
    code_d  = code_q;
    if (fall_q) begin
      case (state_q)
        IDLE: begin
          if (!dat_c) begin
            state_d = DATA;
            bcnt_d  = '0;
          end
        end
        DATA: begin
          shift_d = {dat_c, shift_q[7:1]};
          bcnt_d  = bcnt_q + 3'd1;
          if (bcnt_q == 3'd7) state_d = PAR;
        end
        PAR: begin
          par_d   = dat_c;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (dat_c && (^{shift_q, par_q})) begin
            vld_d  = 1'b1;
            code_d = shift_q;
          end else begin
            err_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (tmo_hit_c) begin
      state_d = IDLE;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge mck) begin
    if (rst) begin
      state_q <= IDLE;
      bcnt_q  <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  // Scancode decoder: prefixes accumulate until a non-prefix byte consumes them
  always_comb begin
    kbmat_d = kbmat_q;
    ext_d   = ext_q;
    brk_d   = brk_q;
    lk_c    = rom_lookup(ext_q, code_q);
    if (tmo_hit_c) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (vld_q) begin
      case (code_q)
        8'hE0: ext_d = 1'b1;
        8'hF0: brk_d = 1'b1;
        8'hAA, 8'hFC, 8'h00, 8'hFF: begin
          kbmat_d = '0;
          ext_d   = 1'b0;
          brk_d   = 1'b0;
        end
        default: begin
          if (lk_c[6]) kbmat_d[lk_c[5:0]] = ~brk_q;
          ext_d = 1'b0;
          brk_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge mck) begin
    if (rst) begin
      kbmat_q <= '0;
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
    end else begin
      kbmat_q <= kbmat_d;
      ext_q   <= ext_d;
      brk_q   <= brk_d;
    end
  end

  assign kbmat     = kbmat_q;
  assign scan_vld  = vld_q;
  assign scan_code = code_q;
  assign frm_err   = err_q;

endmodule
